// File: rtl/decoder_scan_sequencer_if.sv
// Scan request / decoder drive bundle for decoder_scan_sequencer.
// Optional SCAN_MASK_EN adds the per-frame line mask input.
interface decoder_scan_sequencer_if #(
    parameter int DWELL_W = 16
);
    logic               enable_i;
    logic               oneshot_i;
    logic [DWELL_W-1:0] dwell_i;
`ifdef SCAN_MASK_EN
    logic [7:0]         mask_i;
`endif
    logic               select_a_o;
    logic               select_b_o;
    logic               select_c_o;
    logic               g1_o;
    logic               g2a_n_o;
    logic               g2b_n_o;
    logic [2:0]         line_o;
    logic               busy_o;
    logic               frame_done_o;

    modport master (
        input  enable_i, oneshot_i, dwell_i,
`ifdef SCAN_MASK_EN
        input  mask_i,
`endif
        output select_a_o, select_b_o, select_c_o,
        output g1_o, g2a_n_o, g2b_n_o,
        output line_o, busy_o, frame_done_o
    );

    modport slave (
        output enable_i, oneshot_i, dwell_i,
`ifdef SCAN_MASK_EN
        output mask_i,
`endif
        input  select_a_o, select_b_o, select_c_o,
        input  g1_o, g2a_n_o, g2b_n_o,
        input  line_o, busy_o, frame_done_o
    );
endinterface

// File: rtl/decoder_scan_sequencer.sv
// Break-before-make line scanner driving a 3-to-8 active-low decoder.
// Define SCAN_MASK_EN to add per-frame line skipping via mask_i.
module decoder_scan_sequencer #(
    parameter int DWELL_W      = 16,
    parameter int BLANK_CYCLES = 2
) (
    input logic                      clk_i,
    input logic                      rst_n_i,
    decoder_scan_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, BLANK, ACTIVE} state_e;

    localparam logic [3:0] BLANK_LOAD = 4'(BLANK_CYCLES - 1);

    state_e             state_q, state_d;
    logic [2:0]         line_q, line_d;
    logic [3:0]         blank_q, blank_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               cont_q, cont_d;
    logic [7:0]         mask_q, mask_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [7:0]         mask_in;

`ifdef SCAN_MASK_EN
    assign mask_in = bus.mask_i;
`else
    assign mask_in = 8'hFF;
`endif

    function automatic logic [2:0] first_line(input logic [7:0] m);
        first_line = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) first_line = 3'(i);
    endfunction

    function automatic logic [2:0] next_line(input logic [7:0] m,
                                             input logic [2:0] l);
        next_line = l;
        for (int i = 7; i >= 0; i--)
            if (m[i] && i > int'(l)) next_line = 3'(i);
    endfunction

    function automatic logic has_next(input logic [7:0] m,
                                      input logic [2:0] l);
        has_next = 1'b0;
        for (int i = 0; i < 8; i++)
            if (m[i] && i > int'(l)) has_next = 1'b1;
    endfunction

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        blank_d = blank_q;
        dwell_d = dwell_q;
        cont_d  = cont_q;
        mask_d  = mask_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ((bus.enable_i || bus.oneshot_i) && (|mask_in)) begin
                    state_d = BLANK;
                    line_d  = first_line(mask_in);
                    mask_d  = mask_in;
                    cont_d  = bus.enable_i;
                    blank_d = BLANK_LOAD;
                end
            end
            BLANK: begin
                if (blank_q == 4'd0) begin
                    state_d = ACTIVE;
                    dwell_d = (bus.dwell_i == '0) ? '0
                            : bus.dwell_i - DWELL_W'(1);
                end else begin
                    blank_d = blank_q - 4'd1;
                end
            end
            ACTIVE: begin
                if (dwell_q != '0) begin
                    dwell_d = dwell_q - DWELL_W'(1);
                end else if (has_next(mask_q, line_q)) begin
                    state_d = BLANK;
                    line_d  = next_line(mask_q, line_q);
                    blank_d = BLANK_LOAD;
                end else begin
                    // Frame end: wrap only while continuous scan is still requested.
                    done_d = 1'b1;
                    if (cont_q && bus.enable_i && (|mask_in)) begin
                        state_d = BLANK;
                        line_d  = first_line(mask_in);
                        mask_d  = mask_in;
                        blank_d = BLANK_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        en_d   = (state_d == ACTIVE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            line_q  <= 3'd0;
            blank_q <= 4'd0;
            dwell_q <= '0;
            cont_q  <= 1'b0;
            mask_q  <= 8'hFF;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            blank_q <= blank_d;
            dwell_q <= dwell_d;
            cont_q  <= cont_d;
            mask_q  <= mask_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.select_a_o   = line_q[0];
    assign bus.select_b_o   = line_q[1];
    assign bus.select_c_o   = line_q[2];
    assign bus.line_o       = line_q;
    assign bus.g1_o         = en_q;
    assign bus.g2a_n_o      = ~en_q;
    assign bus.g2b_n_o      = ~en_q;
    assign bus.busy_o       = busy_q;
    assign bus.frame_done_o = done_q;
endmodule
